lm32_wb_timer: RTL and testbench

- Wishbone slave timer peripheral on the LatticeMico32 data bus.
- Consumes the CPU data Wishbone master cycles, after address decode by the system interconnect.
- Drives one active-low interrupt line into the CPU interrupt_n vector.
- Provides a prescaled 32-bit down-counter with period reload, one-shot or auto-reload mode, and a sticky timeout flag.

---
 rtl/lm32_wb_timer_if.sv | 26 ++
 rtl/lm32_wb_timer.sv | 143 ++++++++++++++
 tb/tb_lm32_wb_timer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/lm32_wb_timer_if.sv
// Wishbone classic slave port bundle for the LM32 timer.
// Signal names follow the Wishbone datasheet (slave view).
interface lm32_wb_timer_if;
  logic [31:0] ADR_I;
  logic [31:0] DAT_I;
  logic [3:0]  SEL_I;
  logic        WE_I;
  logic        CYC_I;
  logic        STB_I;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        ERR_O;
  logic        RTY_O;

  modport master (
    output ADR_I, DAT_I, SEL_I,
    output WE_I, CYC_I, STB_I,
    input  DAT_O, ACK_O, ERR_O, RTY_O
  );

  modport slave (
    input  ADR_I, DAT_I, SEL_I,
    input  WE_I, CYC_I, STB_I,
    output DAT_O, ACK_O, ERR_O, RTY_O
  );
endinterface

// File: rtl/lm32_wb_timer.sv
// Prescaled down-counting timer with sticky timeout flag
// and active-low interrupt, on a registered Wishbone slave.
module lm32_wb_timer #(
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  lm32_wb_timer_if.slave wb,
  output logic           irq_n
);

  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(PRESCALE - 1);
  localparam int unsigned CW = COUNT_WIDTH;

  logic          en;
  logic          ar;
  logic          ie;
  logic          to;
  logic [CW-1:0] period;
  logic [CW-1:0] count;
  logic [PW-1:0] pre;

  logic          req;
  logic          wr_ok;
  logic          wr_bad;
  logic [1:0]    reg_sel;
  logic          wr_ctrl;
  logic          wr_status;
  logic          wr_period;
  logic          wr_count;
  logic          tick;
  logic          expire;
  logic          to_clr;
  logic [31:0]   rd_data;

  logic unused_adr;
  assign unused_adr =
    ^{wb.ADR_I[31:4], wb.ADR_I[1:0]};

  assign reg_sel = wb.ADR_I[3:2];
  assign req = wb.STB_I & wb.CYC_I &
               ~wb.ACK_O & ~wb.ERR_O;
  assign wr_ok = req & wb.WE_I &
                 (wb.SEL_I == 4'hF);
  assign wr_bad = req & wb.WE_I &
                  (wb.SEL_I != 4'hF);

  assign wr_ctrl   = wr_ok & (reg_sel == 2'd0);
  assign wr_status = wr_ok & (reg_sel == 2'd1);
  assign wr_period = wr_ok & (reg_sel == 2'd2);
  assign wr_count  = wr_ok & (reg_sel == 2'd3);

  // A COUNT write in a tick cycle swallows that tick.
  assign tick   = en & (pre == PRE_MAX);
  assign expire = tick & (count == '0) & ~wr_count;
  assign to_clr = wr_status & wb.DAT_I[0];

  assign wb.RTY_O = 1'b0;

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      (reg_sel == 2'd0): rd_data[2:0] = {ie, ar, en};
      (reg_sel == 2'd1): rd_data[0]   = to;
      (reg_sel == 2'd2): rd_data[CW-1:0] = period;
      (reg_sel == 2'd3): rd_data[CW-1:0] = count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb.ACK_O <= 1'b0;
      wb.ERR_O <= 1'b0;
      wb.DAT_O <= '0;
      irq_n    <= 1'b1;
    end else begin
      wb.ACK_O <= req & ~wr_bad;
      wb.ERR_O <= wr_bad;
      if (req) wb.DAT_O <= rd_data;
      irq_n    <= ~(to & ie);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre <= '0;
    end else if (!en || wr_ctrl || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // A bus write to CTRL overrides one-shot EN clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en <= 1'b0;
      ar <= 1'b0;
      ie <= 1'b0;
    end else if (wr_ctrl) begin
      {ie, ar, en} <= wb.DAT_I[2:0];
    end else if (expire && !ar) begin
      en <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to <= 1'b0;
    end else if (expire) begin
      to <= 1'b1;
    end else if (to_clr) begin
      to <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period <= '0;
    end else if (wr_period) begin
      period <= wb.DAT_I[CW-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (wr_count) begin
      count <= wb.DAT_I[CW-1:0];
    end else if (tick) begin
      if (count != '0) begin
        count <= count - 1'b1;
      end else if (ar) begin
        count <= period;
      end
    end
  end

endmodule

// File: tb/tb_lm32_wb_timer.sv
// Randomized bench for lm32_wb_timer: two instances share
// one bus stimulus and are checked against a cycle model.
module tb_lm32_wb_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = 4'hF;
  logic        we  = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        irq_a;
  logic        irq_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lm32_wb_timer_if ia ();
  lm32_wb_timer_if ib ();

  assign ia.ADR_I = adr;
  assign ia.DAT_I = dat;
  assign ia.SEL_I = sel;
  assign ia.WE_I  = we;
  assign ia.CYC_I = cyc;
  assign ia.STB_I = stb;
  assign ib.ADR_I = adr;
  assign ib.DAT_I = dat;
  assign ib.SEL_I = sel;
  assign ib.WE_I  = we;
  assign ib.CYC_I = cyc;
  assign ib.STB_I = stb;

  lm32_wb_timer #(
    .PRESCALE(1), .COUNT_WIDTH(32)
  ) u_a (
    .clk_i(clk), .rst_i(rst),
    .wb(ia), .irq_n(irq_a)
  );

  lm32_wb_timer #(
    .PRESCALE(4), .COUNT_WIDTH(8)
  ) u_b (
    .clk_i(clk), .rst_i(rst),
    .wb(ib), .irq_n(irq_b)
  );

  // reference model state, one slot per instance
  int          ps   [2] = '{1, 4};
  logic [31:0] mask [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  bit          m_en [2];
  bit          m_ar [2];
  bit          m_ie [2];
  bit          m_to [2];
  bit          m_ack[2];
  bit          m_err[2];
  bit          m_irq[2];
  logic [31:0] m_per[2];
  logic [31:0] m_cnt[2];
  logic [31:0] m_dat[2];
  int          m_ph [2];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_step(int k);
    bit          req, good, bad, tick, tmo, wcnt;
    int          r;
    logic [31:0] rv;
    if (rst) begin
      m_en[k] = 0; m_ar[k] = 0; m_ie[k] = 0;
      m_to[k] = 0; m_ack[k] = 0; m_err[k] = 0;
      m_irq[k] = 1; m_per[k] = 0; m_cnt[k] = 0;
      m_dat[k] = 0; m_ph[k] = 0;
      return;
    end
    r    = int'(adr[3:2]);
    req  = stb && cyc && !m_ack[k] && !m_err[k];
    good = req && we && (sel == 4'hF);
    bad  = req && we && (sel != 4'hF);
    case (r)
      0: rv = {29'd0, m_ie[k], m_ar[k], m_en[k]};
      1: rv = {31'd0, m_to[k]};
      2: rv = m_per[k];
      default: rv = m_cnt[k];
    endcase
    tick = m_en[k] && (m_ph[k] == ps[k] - 1);
    wcnt = good && (r == 3);
    tmo  = tick && (m_cnt[k] == 0) && !wcnt;
    m_irq[k] = !(m_to[k] && m_ie[k]);
    if (req) m_dat[k] = rv;
    m_ack[k] = req && !bad;
    m_err[k] = bad;
    if (!m_en[k] || (good && r == 0))
      m_ph[k] = 0;
    else
      m_ph[k] = (m_ph[k] + 1) % ps[k];
    if (wcnt)
      m_cnt[k] = dat & mask[k];
    else if (tick)
      m_cnt[k] = (m_cnt[k] != 0) ? m_cnt[k] - 1 :
                 (m_ar[k] ? m_per[k] : 32'd0);
    m_to[k] = tmo ||
      (m_to[k] && !(good && r == 1 && dat[0]));
    if (good && r == 0) begin
      m_en[k] = dat[0];
      m_ar[k] = dat[1];
      m_ie[k] = dat[2];
    end else if (tmo && !m_ar[k]) begin
      m_en[k] = 0;
    end
    if (good && r == 2) m_per[k] = dat & mask[k];
  endtask

  task automatic cmp_dut(string n, int k,
                         logic ack, logic err,
                         logic rty, logic irq,
                         logic [31:0] d);
    chk({n, ".ack"}, {31'd0, ack}, {31'd0, m_ack[k]});
    chk({n, ".err"}, {31'd0, err}, {31'd0, m_err[k]});
    chk({n, ".rty"}, {31'd0, rty}, 32'd0);
    chk({n, ".irq_n"}, {31'd0, irq}, {31'd0, m_irq[k]});
    if (ack)
      chk({n, ".dat"}, d, m_dat[k]);
  endtask

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    cmp_dut("a", 0, ia.ACK_O, ia.ERR_O,
            ia.RTY_O, irq_a, ia.DAT_O);
    cmp_dut("b", 1, ib.ACK_O, ib.ERR_O,
            ib.RTY_O, irq_b, ib.DAT_O);
  endtask

  task automatic bus(bit s, bit w, int r,
                     logic [31:0] d, logic [3:0] sl);
    stb = s;
    cyc = s;
    we  = w;
    adr = {28'd0, 2'(r), 2'd0};
    dat = d;
    sel = sl;
  endtask

  task automatic xfer(bit w, int r, logic [31:0] d,
                      logic [3:0] sl);
    bus(1, w, r, d, sl);
    cycle();
    bus(0, 0, 0, 32'd0, 4'hF);
    cycle();
  endtask

  task automatic idle(int n);
    bus(0, 0, 0, 32'd0, 4'hF);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int r = 0; r < 4; r++) xfer(0, r, 0, 4'hF);

    xfer(1, 2, 32'd3, 4'hF);
    xfer(1, 3, 32'd3, 4'hF);
    xfer(1, 0, 32'd7, 4'hF);
    idle(20);
    xfer(1, 1, 32'd1, 4'hF);
    idle(6);
    xfer(0, 1, 0, 4'hF);
    xfer(1, 3, 32'd10, 4'hF);
    xfer(0, 3, 0, 4'hF);

    xfer(1, 0, 32'd0, 4'hF);
    xfer(1, 3, 32'd2, 4'hF);
    xfer(1, 0, 32'd1, 4'hF);
    idle(14);
    xfer(0, 0, 0, 4'hF);
    xfer(0, 3, 0, 4'hF);

    xfer(1, 2, 32'h55, 4'h3);
    xfer(0, 2, 0, 4'h1);

    // back-to-back held strobe
    bus(1, 0, 2, 0, 4'hF);
    for (int i = 0; i < 4; i++) cycle();

    xfer(1, 0, 32'd3, 4'hF);
    idle(3);
    bus(1, 0, 3, 0, 4'hF);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle(1);
    for (int r = 0; r < 4; r++) xfer(0, r, 0, 4'hF);

    for (int i = 0; i < 4000; i++) begin
      logic [31:0] d;
      int          r;
      r = int'($urandom_range(0, 3));
      d = ($urandom_range(0, 3) == 0) ? $urandom :
          32'($urandom_range(0, 7));
      rst = ($urandom_range(0, 399) == 0);
      bus($urandom_range(0, 2) != 0,
          $urandom_range(0, 1) == 1, r, d,
          ($urandom_range(0, 4) == 0) ?
            4'($urandom) : 4'hF);
      adr[31:4] = 28'($urandom);
      adr[1:0]  = 2'($urandom);
      cyc = stb ? ($urandom_range(0, 7) != 0) : 1'b0;
      cycle();
    end
    rst = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
